alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one combinational `alu` instance among NREQ requesters. Each requester
//   presents an instruction word and two operands; a round-robin arbiter picks one,
//   runs it through the ALU from registered inputs and returns the registered
//   result and flags, tagged with the requester ID. Sits between issue logic and
//   the shared ALU; the ALU's opcode/funct decode is reused unchanged.
// PARAMETERS
//   NREQ   4   number of requesters (2..8)
//   ID_W   2   width of requester ID, >= clog2(NREQ)
//   CNT_W  16  width of saturating overflow-event counter
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous reset, active low
//   req_valid  in   NREQ     bit i: requester i has an operation pending
//   req_ready  out  NREQ     bit i: requester i's operation accepted this cycle
//   req_instr  in   32*NREQ  requester i instruction at [32*i+31:32*i]
//   req_rega   in   32*NREQ  requester i regA at [32*i+31:32*i]
//   req_regb   in   32*NREQ  requester i regB at [32*i+31:32*i]
//   rsp_valid  out  1        response available
//   rsp_ready  in   1        consumer accepts response
//   rsp_id     out  ID_W     requester ID of the response
//   rsp_result out  32       ALU result
//   rsp_flags  out  3        [2] zero, [1] negative, [0] overflow (as from alu)
//   busy       out  1        1 when state != IDLE
//   ovf_count  out  CNT_W    number of completed ops with flags[0]=1, saturating
// BEHAVIOUR
// - Reset (rst_n=0, async): state=IDLE; rsp_valid, rsp_id, rsp_result, rsp_flags,
//   busy, ovf_count = 0; req_ready = 0; rr pointer = NREQ-1 (requester 0 wins first).
// - FSM: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if any req_valid, winner = first set bit searching from ptr+1 upward,
//     wrapping. req_ready[winner]=1 combinationally, all other bits 0. On that
//     edge, capture instr/regA/regB/ID into operand regs, set ptr=winner, go to EXEC.
//     With no req_valid, stay in IDLE with req_ready=0.
//   EXEC: ALU driven only from operand regs. On the edge, latch result/flags into
//     rsp regs, set rsp_valid=1, increment ovf_count if flags[0]=1 and not at all-ones,
//     go to RESP.
//   RESP: rsp_* held stable. On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE.
// - req_ready is never asserted in EXEC or RESP, so there is no new grant while
//   a response is pending.
// - Latency: grant edge -> rsp_valid high 2 cycles later. Peak throughput is
//   1 op per 3 cycles.
// - Requesters hold instr/operands stable while req_valid=1 until req_ready.
//   Dropping req_valid before grant is legal and is ignored.
// - No decode in the arbiter: unsupported opcodes return whatever alu produces.
//   addu/addiu overflow flag is taken as reported by alu.
// - rsp_id = index of the granted requester, zero-extended to ID_W.
// - Reset mid-operation aborts the op: no response, ovf_count cleared.
// - No output depends combinationally on rsp_ready. req_ready depends only on
//   state, ptr and req_valid.
// TESTING
// 1 req_valid=0001, instr 0x00014020, A=4, B=5 -> req_ready=0001 at cycle g;
//   at g+2: rsp_valid=1, id=0, result=9, flags=000.
// 2 req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every
//   3 cycles.
// 3 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0000, busy=1;
//   then rsp_ready=1 -> IDLE next edge.
// 4 add, A=0x7FFFFFF8, B=0x7FFFFFF9 -> result 0xFFFFFFF1, flags[0]=1, ovf_count
//   +1; with CNT_W=2, four overflows -> ovf_count stays 3.
// 5 addi, instr 0x2020FF9C, B=19 -> result 0xFFFFFFAF (-81), flags=010.
// 6 rst_n=0 during EXEC -> rsp_valid=0 and busy=0 immediately; after release with
//   req_valid=1111, the first grant goes to req 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU among NREQ requesters.
// A winner's instruction and operands are captured into registers, the ALU runs
// from those registers for one cycle, and the result is held until consumed.

// Shared combinational ALU. R-type ops use regA/regB; I-type ops and shifts
// take regB as their register source.
module alu (
  input  logic [31:0] instr_i,
  input  logic [31:0] rega_i,
  input  logic [31:0] regb_i,
  output logic [31:0] result_o,
  output logic [2:0]  flags_o
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic        ovf;
  logic        unused_reg_fields;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];
  assign shamt  = instr_i[10:6];
  assign imm_s  = {{16{instr_i[15]}}, instr_i[15:0]};
  assign imm_z  = {16'h0000, instr_i[15:0]};
  // Register-number fields are resolved by the issue logic, not here.
  assign unused_reg_fields = ^instr_i[25:16];

  // Opcode/funct decode; unsupported encodings yield zero with no overflow.
  always_comb begin
    result_o = 32'h0;
    ovf      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:  result_o = regb_i << shamt;
          FN_SRL:  result_o = regb_i >> shamt;
          FN_SRA:  result_o = $unsigned($signed(regb_i) >>> shamt);
          FN_ADD: begin
            result_o = rega_i + regb_i;
            ovf      = (rega_i[31] == regb_i[31]) && (result_o[31] != rega_i[31]);
          end
          FN_ADDU: result_o = rega_i + regb_i;
          FN_SUB: begin
            result_o = rega_i - regb_i;
            ovf      = (rega_i[31] != regb_i[31]) && (result_o[31] != rega_i[31]);
          end
          FN_SUBU: result_o = rega_i - regb_i;
          FN_AND:  result_o = rega_i & regb_i;
          FN_OR:   result_o = rega_i | regb_i;
          FN_XOR:  result_o = rega_i ^ regb_i;
          FN_NOR:  result_o = ~(rega_i | regb_i);
          FN_SLT:  result_o = {31'h0, $signed(rega_i) < $signed(regb_i)};
          FN_SLTU: result_o = {31'h0, rega_i < regb_i};
          default: result_o = 32'h0;
        endcase
      end
      OP_ADDI: begin
        result_o = regb_i + imm_s;
        ovf      = (regb_i[31] == imm_s[31]) && (result_o[31] != regb_i[31]);
      end
      OP_ADDIU: result_o = regb_i + imm_s;
      OP_SLTI:  result_o = {31'h0, $signed(regb_i) < $signed(imm_s)};
      OP_SLTIU: result_o = {31'h0, regb_i < imm_s};
      OP_ANDI:  result_o = regb_i & imm_z;
      OP_ORI:   result_o = regb_i | imm_z;
      OP_XORI:  result_o = regb_i ^ imm_z;
      OP_LUI:   result_o = {instr_i[15:0], 16'h0000};
      default:  result_o = 32'h0;
    endcase
    flags_o = {(result_o == 32'h0), result_o[31], ovf};
  end
endmodule

module alu_arbiter #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_instr,
  input  logic [32*NREQ-1:0]   req_rega,
  input  logic [32*NREQ-1:0]   req_regb,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic [2:0]           rsp_flags,
  output logic                 busy,
  output logic [CNT_W-1:0]     ovf_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  winner;
  logic             any_valid;
  logic             grant;

  logic [31:0]      op_instr_q, op_rega_q, op_regb_q;
  logic [ID_W-1:0]  op_id_q;
  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [31:0]      rsp_result_q;
  logic [2:0]       rsp_flags_q;
  logic [CNT_W-1:0] ovf_count_q;

  logic [31:0]      alu_result;
  logic [2:0]       alu_flags;

  logic [31:0]      instr_arr [NREQ];
  logic [31:0]      rega_arr  [NREQ];
  logic [31:0]      regb_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign instr_arr[gi] = req_instr[32*gi +: 32];
    assign rega_arr[gi]  = req_rega[32*gi +: 32];
    assign regb_arr[gi]  = req_regb[32*gi +: 32];
  end

  // Round-robin search: first valid requester after ptr, wrapping around.
  always_comb begin
    any_valid = |req_valid;
    winner    = ptr_q;
    for (int i = NREQ; i >= 1; i--) begin
      int j;
      j = (int'(ptr_q) + i) % NREQ;
      if (req_valid[j]) winner = ID_W'(j);
    end
  end

  assign grant = (state_q == IDLE) && any_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: one-hot ready to the winner only while idle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (winner == ID_W'(i));
    end
    busy = (state_q != IDLE);
  end

  alu u_alu (
    .instr_i  (op_instr_q),
    .rega_i   (op_rega_q),
    .regb_i   (op_regb_q),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  // Datapath: operand capture on grant, response capture after execution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= ID_W'(NREQ - 1);
      op_instr_q   <= '0;
      op_rega_q    <= '0;
      op_regb_q    <= '0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      ovf_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            op_instr_q <= instr_arr[winner];
            op_rega_q  <= rega_arr[winner];
            op_regb_q  <= regb_arr[winner];
            op_id_q    <= winner;
            ptr_q      <= winner;
          end
        end
        EXEC: begin
          rsp_valid_q  <= 1'b1;
          rsp_id_q     <= op_id_q;
          rsp_result_q <= alu_result;
          rsp_flags_q  <= alu_flags;
          if (alu_flags[0] && (ovf_count_q != {CNT_W{1'b1}})) begin
            ovf_count_q <= ovf_count_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign ovf_count  = ovf_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: scoreboard of expected responses pushed at
// grant time, compared when the response appears.
module tb_alu_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_instr, req_rega, req_regb;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic [2:0]   rsp_flags;
  logic         busy;
  logic [15:0]  ovf_count;

  logic [3:0]   unused_s_ready;
  logic         unused_s_valid, unused_s_busy;
  logic [1:0]   unused_s_id;
  logic [31:0]  unused_s_result;
  logic [2:0]   unused_s_flags;
  logic [1:0]   ovf_small;

  logic [31:0]  ins [4];
  logic [31:0]  ra  [4];
  logic [31:0]  rb  [4];

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;
  exp_t sb [$];

  int n_cmp = 0;
  int n_err = 0;
  int exp_ovf = 0;

  always #5 clk = ~clk;

  assign req_instr = {ins[3], ins[2], ins[1], ins[0]};
  assign req_rega  = {ra[3], ra[2], ra[1], ra[0]};
  assign req_regb  = {rb[3], rb[2], rb[1], rb[0]};

  alu_arbiter #(.NREQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_rega(req_rega), .req_regb(req_regb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy),
    .ovf_count(ovf_count)
  );

  // Narrow-counter copy, driven identically, to observe saturation at 3.
  alu_arbiter #(.NREQ(4), .ID_W(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(unused_s_ready),
    .req_instr(req_instr), .req_rega(req_rega), .req_regb(req_regb),
    .rsp_valid(unused_s_valid), .rsp_ready(rsp_ready), .rsp_id(unused_s_id),
    .rsp_result(unused_s_result), .rsp_flags(unused_s_flags), .busy(unused_s_busy),
    .ovf_count(ovf_small)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU for the operations the bench issues.
  function automatic exp_t model(input logic [1:0] id, input logic [31:0] in,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] r, imm;
    logic v;
    r = 32'h0; v = 1'b0;
    imm = {{16{in[15]}}, in[15:0]};
    if (in[31:26] == 6'h00) begin
      if (in[5:0] == 6'h20) begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      else if (in[5:0] == 6'h21) r = a + b;
      else if (in[5:0] == 6'h22) begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      else if (in[5:0] == 6'h25) r = a | b;
    end else if (in[31:26] == 6'h08) begin
      r = b + imm; v = (b[31] == imm[31]) && (r[31] != b[31]);
    end
    e.id = id; e.res = r; e.flg = {(r == 32'h0), r[31], v};
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 4'b0; rsp_ready = 1'b0;
    sb.delete(); exp_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'h0);
    check("rst_ovf", 32'(ovf_count), 32'h0);
    rst_n = 1'b1;
  endtask

  // One full transaction: wait for grant to exp_id, expect response two edges
  // later, optionally stall the consumer, then accept.
  task automatic serve(input int exp_id, input int stall, input bit drop, output int gwait);
    exp_t e, m;
    int k;
    rsp_ready = (stall == 0);
    k = 0;
    @(negedge clk);
    while (req_ready == 4'b0 && k < 20) begin @(negedge clk); k++; end
    gwait = k;
    check($sformatf("grant%0d", exp_id), 32'(req_ready), 32'(4'b0001 << exp_id));
    m = model(2'(exp_id), ins[exp_id], ra[exp_id], rb[exp_id]);
    sb.push_back(m);
    @(posedge clk); #1;
    if (drop) req_valid[exp_id] = 1'b0;
    @(negedge clk);
    check("exec_busy", 32'(busy), 32'h1);
    check("exec_no_ready", 32'(req_ready), 32'h0);
    k = 0;
    while (!rsp_valid && k < 10) begin @(negedge clk); k++; end
    check("latency", 32'(k), 32'h1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'h0, 32'h1);
    end else begin
      e = sb.pop_front();
      $display("rsp id=%0d result=0x%08h flags=%03b", rsp_id, rsp_result, rsp_flags);
      check("rsp_id", 32'(rsp_id), 32'(e.id));
      check("rsp_result", rsp_result, e.res);
      check("rsp_flags", 32'(rsp_flags), 32'(e.flg));
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", 32'(rsp_valid), 32'h1);
        check("stall_result", rsp_result, e.res);
        check("stall_id", 32'(rsp_id), 32'(e.id));
        check("stall_ready", 32'(req_ready), 32'h0);
        check("stall_busy", 32'(busy), 32'h1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("idle_after_ack", {30'h0, busy, rsp_valid}, 32'h0);
      if (e.flg[0]) exp_ovf++;
      check("ovf_count", 32'(ovf_count), 32'(exp_ovf));
      check("ovf_sat", 32'(ovf_small), 32'((exp_ovf > 3) ? 3 : exp_ovf));
    end
  endtask

  initial begin
    int gw;
    for (int i = 0; i < 4; i++) begin ins[i] = 32'h0; ra[i] = 32'h0; rb[i] = 32'h0; end
    do_reset();

    // Single request from requester 0: add 4 + 5.
    ins[0] = 32'h00014020; ra[0] = 32'd4; rb[0] = 32'd5;
    req_valid = 4'b0001;
    serve(0, 0, 1'b1, gw);

    // All requesters pending: strict rotation 0,1,2,3,0 from reset.
    do_reset();
    ins[1] = 32'h00000022; ra[1] = 32'd10;        rb[1] = 32'd10;
    ins[2] = 32'h00000025; ra[2] = 32'hF0F00000;  rb[2] = 32'h00000F0F;
    ins[3] = 32'h00000021; ra[3] = 32'hFFFFFFFF;  rb[3] = 32'h00000001;
    req_valid = 4'b1111;
    serve(0, 0, 1'b0, gw);
    for (int n = 1; n <= 4; n++) begin
      serve(n % 4, 0, 1'b0, gw);
      check("grant_spacing", 32'(gw), 32'h0);
    end

    // Consumer stall for five cycles in RESP.
    serve(1, 5, 1'b0, gw);

    // Signed overflow; five overflows saturate the 2-bit counter at 3.
    for (int i = 0; i < 4; i++) begin
      ins[i] = 32'h00000020; ra[i] = 32'h7FFFFFF8; rb[i] = 32'h7FFFFFF9;
    end
    serve(2, 0, 1'b0, gw);
    serve(3, 0, 1'b0, gw);
    serve(0, 0, 1'b0, gw);
    serve(1, 0, 1'b0, gw);
    serve(2, 0, 1'b0, gw);

    // addi with negative immediate.
    ins[3] = 32'h2020FF9C; rb[3] = 32'd19; ra[3] = 32'h0;
    req_valid = 4'b1000;
    serve(3, 0, 1'b1, gw);

    // Reset during EXEC aborts the op and rewinds the pointer.
    req_valid = 4'b0010; rsp_ready = 1'b1;
    @(negedge clk);
    check("pre_abort_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    check("abort_in_exec", 32'(busy), 32'h1);
    rst_n = 1'b0; #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_ovf", 32'(ovf_count), 32'h0);
    check("abort_ovf_sat", 32'(ovf_small), 32'h0);
    exp_ovf = 0;
    req_valid = 4'b1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    serve(0, 0, 1'b0, gw);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
